// File: rtl/spi_reg_bank.sv
// SPI (mode 0, MSB first) slave exposing a bank of NUM_REGS registers.
// Frame: R/W bit, ADDR_W address bits, DATA_W data bits; sclk/cs_n/copi are oversampled on clk.
module spi_reg_bank #(
  parameter int NUM_REGS = 5,
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sclk,
  input  logic                       cs_n,
  input  logic                       copi,
  output logic                       cipo,
  output logic [NUM_REGS*DATA_W-1:0] regs,
  output logic                       wr_strobe,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic [7:0]                 err_count
);

  localparam int FRAME_W = 1 + ADDR_W + DATA_W;
  localparam int CNT_W   = $clog2(FRAME_W + 1);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DRAIN} state_e;

  state_e             state_q, state_d;
  logic [2:0]         sclk_sync_q, sclk_sync_d;
  logic [2:0]         cs_sync_q, cs_sync_d;
  logic [2:0]         copi_sync_q, copi_sync_d;
  logic [1:0]         settle_q, settle_d;
  logic               armed_q, armed_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [FRAME_W-1:0] shift_q, shift_d;
  logic               overlong_q, overlong_d;
  logic [DATA_W-1:0]  tx_q, tx_d;
  logic [DATA_W-1:0]  regs_q [NUM_REGS];
  logic [DATA_W-1:0]  regs_d [NUM_REGS];
  logic               wr_strobe_q, wr_strobe_d;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
  logic [7:0]         err_count_q, err_count_d;

  logic              sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic [ADDR_W-1:0] load_addr, commit_addr;
  logic [DATA_W-1:0] commit_data, rd_data;
  logic              commit_rw, addr_in_range;

  assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
  assign cs_rise   = cs_sync_q[1] & ~cs_sync_q[2];
  assign cs_fall   = ~cs_sync_q[1] & cs_sync_q[2];

  assign load_addr     = shift_q[ADDR_W-1:0];
  assign commit_rw     = shift_q[FRAME_W-1];
  assign commit_addr   = shift_q[DATA_W +: ADDR_W];
  assign commit_data   = shift_q[DATA_W-1:0];
  assign addr_in_range = int'(commit_addr) < NUM_REGS;

  always_comb begin
    // NOTE: every variable gets a default first so no path through this block can infer a latch.
    sclk_sync_d = {sclk_sync_q[1:0], sclk};
    cs_sync_d   = {cs_sync_q[1:0], cs_n};
    copi_sync_d = {copi_sync_q[1:0], copi};
    settle_d    = (settle_q == 2'd3) ? settle_q : settle_q + 2'd1;
    // A frame may only start after cs_n has been seen high with the synchronizer flushed,
    // so a cs_n held low across reset cannot start a half frame.
    armed_d     = armed_q | ((settle_q == 2'd3) & cs_sync_q[2]);
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    overlong_d  = overlong_q;
    tx_d        = tx_q;
    regs_d      = regs_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    err_count_d = err_count_q;

    rd_data = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (load_addr == ADDR_W'(k)) rd_data = regs_q[k];
    end

    case (state_q)
      IDLE: begin
        if (cs_fall && armed_q) begin
          state_d    = ADDR;
          bit_cnt_d  = '0;
          shift_d    = '0;
          overlong_d = 1'b0;
        end
      end
      ADDR, DATA: begin
        if (sclk_rise) begin
          shift_d   = {shift_q[FRAME_W-2:0], copi_sync_q[1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (state_q == ADDR && bit_cnt_q == CNT_W'(ADDR_W)) state_d = DATA;
          if (state_q == DATA && bit_cnt_q == CNT_W'(FRAME_W - 1)) state_d = DRAIN;
        end
        if (sclk_fall && state_q == DATA) begin
          if (bit_cnt_q == CNT_W'(ADDR_W + 1) && !shift_q[ADDR_W]) tx_d = rd_data;
          else tx_d = tx_q << 1;
        end
      end
      DRAIN: begin
        if (sclk_rise) overlong_d = 1'b1;
        if (sclk_fall) tx_d = tx_q << 1;
      end
      default: state_d = IDLE;
    endcase

    if (cs_rise) begin
      state_d = IDLE;
      tx_d    = '0;
      if (state_q == ADDR || state_q == DATA) begin
        if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
      end else if (state_q == DRAIN) begin
        if (overlong_q || (commit_rw && !addr_in_range)) begin
          if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
        end else if (commit_rw) begin
          for (int k = 0; k < NUM_REGS; k++) begin
            if (commit_addr == ADDR_W'(k)) regs_d[k] = commit_data;
          end
          wr_strobe_d = 1'b1;
          wr_addr_d   = commit_addr;
        end
      end
    end
  end

  // NOTE: sequential state uses <= only, so every flop samples the pre-edge value of its _d.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sclk_sync_q <= 3'b000;
      cs_sync_q   <= 3'b111;
      copi_sync_q <= 3'b000;
      settle_q    <= '0;
      armed_q     <= 1'b0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      overlong_q  <= 1'b0;
      tx_q        <= '0;
      // NOTE: the register array is a small flop bank with a defined reset value, not a RAM.
      for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= '0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      sclk_sync_q <= sclk_sync_d;
      cs_sync_q   <= cs_sync_d;
      copi_sync_q <= copi_sync_d;
      settle_q    <= settle_d;
      armed_q     <= armed_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      overlong_q  <= overlong_d;
      tx_q        <= tx_d;
      regs_q      <= regs_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      err_count_q <= err_count_d;
    end
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_regs
    assign regs[k*DATA_W +: DATA_W] = regs_q[k];
  end

  assign cipo      = tx_q[DATA_W-1];
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
  assign err_count = err_count_q;

endmodule
